// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the memory responder: FSM state encoding, the
// word-index width helper, and the classification of a byte address into an
// error cause (used by the responder to raise err, and available to benches).
// -----------------------------------------------------------------------------
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } err_cause_t;

  // Ceiling log2, usable in constant expressions (word-index width).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Misalignment takes precedence over range; any word index at or beyond the
  // array depth is an error rather than being wrapped.
  function automatic err_cause_t addr_cause(input logic [31:0] a, input int depth);
    if (a[1:0] != 2'b00) return ERR_MISALIGN;
    if ({2'b00, a[31:2]} >= unsigned'(depth)) return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Request/ready memory bus between the processor control path (master) and the
// memory responder (slave).
//   req   : access request, held by the master until ready
//   we    : 1 = store, 0 = read
//   adr   : byte address
//   wd    : store data
//   rd    : read data
//   ready : one-cycle completion pulse
//   err   : misaligned / out-of-range flag, only with ready
//   busy  : responder is working on an accepted access
// -----------------------------------------------------------------------------
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (output req, we, adr, wd, input rd, ready, err, busy);
  modport slave  (input req, we, adr, wd, output rd, ready, err, busy);
endinterface

// File: rtl/mem_responder_mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port synchronous word RAM with a registered read port. Contents and
// the read register are not reset.
//   clk   : clock
//   i_we  : write i_wd to word i_idx at the rising edge
//   i_re  : load word i_idx into the read register at the rising edge
//   i_idx : word index
//   i_wd  : write data
//   o_rd  : registered read data
// -----------------------------------------------------------------------------
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  localparam int IDX_W = clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wd,
  output logic [31:0]      o_rd
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rd;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wd;
    if (i_re) r_rd <= r_mem[i_idx];
  end

  assign o_rd = r_rd;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the unified instruction/data port. Accepts a
// request in IDLE, waits WAIT_CYCLES cycles, then pulses ready for one cycle
// (RESP) with err set for misaligned or out-of-range addresses. Stores commit
// on the edge that ends RESP; reads are presented during RESP.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of mem_responder_if (req/we/adr/wd in, rd/ready/err/busy out)
// -----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave bus
);

  localparam int         IDX_W    = clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_cnt;
  logic               r_rd_live;
  logic               r_we;
  logic [31:0]        r_adr;
  logic [31:0]        r_wd;

  logic               w_accept;
  logic               w_in_bad;
  logic               w_lat_bad;
  logic               w_ram_we;
  logic               w_ram_re;
  logic               w_rd_clr;
  logic [IDX_W-1:0]   w_idx;
  logic [31:0]        w_ram_rd;

  assign w_accept  = (r_state == IDLE) && bus.req;
  assign w_in_bad  = (addr_cause(bus.adr, DEPTH_WORDS) != ERR_NONE);
  assign w_lat_bad = (addr_cause(r_adr, DEPTH_WORDS) != ERR_NONE);

  // Next state plus RAM controls. The RAM read is launched in the cycle
  // before RESP so its registered output is valid during RESP; with no wait
  // cycles that is the acceptance cycle itself, so the live bus address is used.
  always_comb begin
    w_next   = r_state;
    w_ram_we = 1'b0;
    w_ram_re = 1'b0;
    w_rd_clr = 1'b0;
    w_idx    = r_adr[IDX_W+1:2];
    case (r_state)
      IDLE: begin
        w_idx = bus.adr[IDX_W+1:2];
        if (bus.req) begin
          w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
          if (WAIT_CYCLES == 0 && !bus.we) begin
            w_ram_re = !w_in_bad;
            w_rd_clr = w_in_bad;
          end
        end
      end
      WAIT: begin
        if (!bus.req) begin
          w_next = IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next = RESP;
          if (!r_we) begin
            w_ram_re = !w_lat_bad;
            w_rd_clr = w_lat_bad;
          end
        end
      end
      RESP: begin
        w_next   = IDLE;
        w_ram_we = r_we && !w_lat_bad;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_rd_live <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // rd follows the RAM read register after a good read, and is forced to
      // zero by an erroneous read; stores and aborts leave it alone.
      if (w_ram_re) begin
        r_rd_live <= 1'b1;
      end else if (w_rd_clr) begin
        r_rd_live <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we  <= bus.we;
      r_adr <= bus.adr;
      r_wd  <= bus.wd;
    end
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem_array (
    .clk  (clk),
    .i_we (w_ram_we),
    .i_re (w_ram_re),
    .i_idx(w_idx),
    .i_wd (r_wd),
    .o_rd (w_ram_rd)
  );

  assign bus.ready = (r_state == RESP);
  assign bus.err   = (r_state == RESP) && w_lat_bad;
  assign bus.busy  = (r_state != IDLE);
  assign bus.rd    = r_rd_live ? w_ram_rd : 32'd0;

endmodule
